// File: rtl/ser_readout_ctrl.sv
// ser_readout_ctrl: serial readout controller for decimated filter words.
// Captures each decimated word into a one-entry pending buffer and shifts it
// out MSB first over a 3-wire host port (cs_b_i, sclk_i, sdo_o). The host
// pins are asynchronous; they are synchronized and edge-detected here.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit after the LSB.
module ser_readout_ctrl #(
    parameter int DATA_W = 16,
    parameter int N_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              cs_b_i,
    input  logic              sclk_i,
    output logic              sdo_o,
    output logic              drdy_o,
    output logic              overrun_o,
    output logic              busy_o
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Synchronizer chains and history flops (all idle high).
    logic [N_SYNC-1:0] cs_sync_q;
    logic [N_SYNC-1:0] sclk_sync_q;
    logic              cs_prev_q;
    logic              sclk_prev_q;

    // Controller state.
    state_e                 state_q,   state_d;
    logic [DATA_W-1:0]      pend_q,    pend_d;
    logic                   drdy_q,    drdy_d;
    logic                   ovr_q,     ovr_d;
    logic [FRAME_LEN-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;

    logic cs_cur;
    logic sclk_cur;
    logic cs_fall;
    logic cs_rise;
    logic sclk_fall;

    // Frame image of a word: the word itself, optionally followed by its
    // even-parity bit so the parity falls out of the normal MSB-first shift.
    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [DATA_W-1:0] w);
`ifdef SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Two-flop (N_SYNC) synchronizers plus one history flop per host pin.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[N_SYNC-2:0], cs_b_i};
            sclk_sync_q <= {sclk_sync_q[N_SYNC-2:0], sclk_i};
            cs_prev_q   <= cs_sync_q[N_SYNC-1];
            sclk_prev_q <= sclk_sync_q[N_SYNC-1];
        end
    end

    assign cs_cur    = cs_sync_q[N_SYNC-1];
    assign sclk_cur  = sclk_sync_q[N_SYNC-1];
    assign cs_fall   = cs_prev_q & ~cs_cur;
    assign cs_rise   = ~cs_prev_q & cs_cur;
    // sclk activity only counts while the host has the port selected.
    assign sclk_fall = sclk_prev_q & ~sclk_cur & ~cs_cur;

    // State, pending buffer and shift register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            drdy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drdy_q  <= drdy_d;
            ovr_q   <= ovr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, pending-buffer update and serial outputs.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        drdy_d  = drdy_q;
        ovr_d   = ovr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sdo_o   = 1'b0;
        busy_o  = 1'b0;

        // A new word always lands in the pending buffer; overwriting an
        // unread word is flagged, except in LOAD where the old word is
        // being consumed in the same cycle (handled below).
        if (valid_i) begin
            pend_d = data_i;
            drdy_d = 1'b1;
            if (drdy_q) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_o  = 1'b1;
                shift_d = drdy_q ? frame_word(pend_q) : '0;
                cnt_d   = '0;
                drdy_d  = valid_i;
                ovr_d   = 1'b0;
                state_d = cs_rise ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy_o = 1'b1;
                sdo_o  = shift_q[FRAME_LEN-1];
                if (cs_rise) begin
                    // Abort wins over a coincident sclk fall; the word is dropped.
                    state_d = ST_IDLE;
                end else if (sclk_fall) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign drdy_o    = drdy_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_ser_readout_ctrl.sv
// Testbench for ser_readout_ctrl: a host model drives frames over the serial
// port, a reference model predicts each frame, and a monitor assembles the
// bits the host samples and checks them against the expected-frame queue.
// Build with SER_PARITY_EN defined to exercise the parity bit.
module tb_ser_readout_ctrl;

    localparam int DATA_W = 16;
    localparam int N_SYNC = 2;
`ifdef SER_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif
    localparam int HALF = 5;   // sclk = clk/10

    logic              clk     = 1'b0;
    logic              rst_b   = 1'b0;
    logic [DATA_W-1:0] data_i  = '0;
    logic              valid_i = 1'b0;
    logic              cs_b_i  = 1'b1;
    logic              sclk_i  = 1'b0;
    logic              sdo_o;
    logic              drdy_o;
    logic              overrun_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a one-word mailbox with a sticky overwrite flag.
    logic [DATA_W-1:0] m_pend = '0;
    bit                m_drdy = 1'b0;
    bit                m_ovr  = 1'b0;
    longint unsigned   exp_q[$];

    ser_readout_ctrl #(
        .DATA_W (DATA_W),
        .N_SYNC (N_SYNC)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .cs_b_i    (cs_b_i),
        .sclk_i    (sclk_i),
        .sdo_o     (sdo_o),
        .drdy_o    (drdy_o),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bit sequence the host should see for a word: the word, then (with
    // parity) one more bit equal to the number of ones modulo 2.
    function automatic longint unsigned frame_val(input logic [DATA_W-1:0] w);
        longint unsigned v;
        v = longint'(w);
`ifdef SER_PARITY_EN
        v = v * 2 + longint'($countones(w) % 2);
`endif
        return v;
    endfunction

    task automatic send_word(input logic [DATA_W-1:0] w);
        @(negedge clk);
        data_i  = w;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        if (m_drdy) m_ovr = 1'b1;
        m_pend = w;
        m_drdy = 1'b1;
        chk1("drdy_after_valid", drdy_o, 1'b1);
        chk1("overrun_after_valid", overrun_o, m_ovr);
        $display("write %h drdy=%b overrun=%b", w, drdy_o, overrun_o);
    endtask

    task automatic pulse_sclk();
        sclk_i = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk_i = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // One host frame. abort_after<0 runs a full frame; otherwise cs_b rises
    // after that many bits. collide strobes valid_i in the LOAD cycle.
    task automatic do_frame(input int abort_after, input bit collide, input logic [DATA_W-1:0] cdata);
        longint unsigned exp;
        exp = m_drdy ? frame_val(m_pend) : 64'd0;
        @(negedge clk);
        cs_b_i = 1'b0;
        if (abort_after < 0) exp_q.push_back(exp);
        m_drdy = 1'b0;
        m_ovr  = 1'b0;
        // Fall is detected N_SYNC+1 edges later; the next cycle is LOAD.
        repeat (N_SYNC + 1) @(negedge clk);
        if (collide) begin
            data_i  = cdata;
            valid_i = 1'b1;
            m_pend  = cdata;
            m_drdy  = 1'b1;
        end
        @(negedge clk);
        valid_i = 1'b0;
        chk1("shift_busy", busy_o, 1'b1);
        chk1("shift_drdy", drdy_o, m_drdy);
        chk1("shift_overrun", overrun_o, 1'b0);
        chk1("first_bit", sdo_o, exp[FL-1]);
        repeat (4) @(negedge clk);
        for (int i = 0; i < FL; i++) begin
            if (i == abort_after) break;
            pulse_sclk();
        end
        if (abort_after < 0) begin
            chk1("done_sdo", sdo_o, 1'b0);
            chk1("done_busy", busy_o, 1'b0);
        end
        cs_b_i = 1'b1;
        repeat (N_SYNC + 4) @(negedge clk);
        chk1("idle_sdo", sdo_o, 1'b0);
        chk1("idle_busy", busy_o, 1'b0);
        chk1("idle_drdy", drdy_o, m_drdy);
        chk1("idle_overrun", overrun_o, m_ovr);
        $display("frame abort_after=%0d collide=%b expected=%h", abort_after, collide, exp);
    endtask

    // Monitor: assembles bits sampled on each sclk rise within a frame and,
    // for complete frames, pops and compares the expected value.
    initial begin
        logic [63:0]     acc;
        int              nb;
        longint unsigned e;
        forever begin
            @(negedge cs_b_i);
            acc = '0;
            nb  = 0;
            while (cs_b_i == 1'b0) begin
                @(posedge sclk_i or posedge cs_b_i);
                if (cs_b_i == 1'b0) begin
                    acc = {acc[62:0], sdo_o};
                    nb++;
                end
            end
            if (nb == FL) begin
                if (exp_q.size() == 0) begin
                    chk64("frame_unexpected", acc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk64("frame_data", acc, e);
                    $display("rx frame %h expected %h", acc, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int ab;
        int nv;
        repeat (3) @(negedge clk);
        chk1("reset_sdo", sdo_o, 1'b0);
        chk1("reset_drdy", drdy_o, 1'b0);
        chk1("reset_overrun", overrun_o, 1'b0);
        chk1("reset_busy", busy_o, 1'b0);
        rst_b = 1'b1;
        repeat (N_SYNC + 4) @(negedge clk);

        // Single-word readout.
        send_word(16'hA5C3);
        do_frame(-1, 1'b0, '0);

        // Overrun: second word replaces the first.
        send_word(16'h1111);
        send_word(16'h2222);
        do_frame(-1, 1'b0, '0);

        // Empty read.
        do_frame(-1, 1'b0, '0);

        // Collision in the LOAD cycle, then the new word on the next frame.
        send_word(16'h1234);
        do_frame(-1, 1'b1, 16'hBEEF);
        do_frame(-1, 1'b0, '0);

        // Abort after 5 bits; the word is lost.
        send_word(16'h8001);
        do_frame(5, 1'b0, '0);
        do_frame(-1, 1'b0, '0);

        // Asynchronous reset in the middle of SHIFT.
        send_word(16'hFFFF);
        @(negedge clk);
        cs_b_i = 1'b0;
        m_drdy = 1'b0;
        m_ovr  = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) pulse_sclk();
        send_word(16'h0F0F);
        chk1("pre_reset_sdo", sdo_o, 1'b1);
        chk1("pre_reset_busy", busy_o, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        chk1("async_reset_sdo", sdo_o, 1'b0);
        chk1("async_reset_drdy", drdy_o, 1'b0);
        chk1("async_reset_overrun", overrun_o, 1'b0);
        chk1("async_reset_busy", busy_o, 1'b0);
        cs_b_i = 1'b1;
        m_drdy = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (N_SYNC + 4) @(negedge clk);
        $display("reset mid-frame done");
        do_frame(-1, 1'b0, '0);

        // Parity words (odd and even number of ones).
        send_word(16'h0007);
        do_frame(-1, 1'b0, '0);
        send_word(16'h0003);
        do_frame(-1, 1'b0, '0);

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            nv = int'($urandom_range(0, 2));
            for (int j = 0; j < nv; j++) begin
                send_word(DATA_W'($urandom));
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            r  = int'($urandom_range(0, 9));
            ab = (r >= 8) ? int'($urandom_range(1, FL - 1)) : -1;
            do_frame(ab, (r < 2), DATA_W'($urandom));
        end

        repeat (20) @(negedge clk);
        chk64("expected_queue_drained", longint'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
